// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer, a GPR bypass port
// and an optional HI/LO write channel.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int HILO_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_regWe,
  input  logic [REG_W-1:0]  mem_regDest,
  input  logic [DATA_W-1:0] mem_value,
  input  logic              mem_hiloWe,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_regWe,
  output logic [REG_W-1:0]  wb_regDest,
  output logic [DATA_W-1:0] wb_value,
  output logic              wb_hiloWe,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_regDest,
  output logic [DATA_W-1:0] fwd_value,
  output logic [1:0]        count
);

  typedef struct packed {
    logic              reg_we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
    logic              hilo_we;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } entry_t;

  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   ready_reg;

  entry_t in_entry;
  logic   accept;
  logic   drain;

  // Writes to register zero are squashed at capture so nothing downstream
  // (including the bypass) ever sees them.
  assign in_entry.reg_we = mem_regWe & (mem_regDest != '0);
  assign in_entry.dest   = mem_regDest;
  assign in_entry.value  = mem_value;

  generate
    if (HILO_EN != 0) begin : g_hilo
      assign in_entry.hilo_we = mem_hiloWe;
      assign in_entry.hi      = mem_hi;
      assign in_entry.lo      = mem_lo;
    end else begin : g_no_hilo
      assign in_entry.hilo_we = 1'b0;
      assign in_entry.hi      = '0;
      assign in_entry.lo      = '0;
    end
  endgenerate

  assign accept = mem_valid & ready_reg;
  assign drain  = main_valid_reg & wb_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;

    if (flush) begin
      // Payloads are kept so the WB data outputs hold their last value.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (drain) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next = in_entry;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_reg) begin
        skid_next       = in_entry;
        skid_valid_next = 1'b1;
      end else begin
        main_next       = in_entry;
        main_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ~skid_valid_next;
    end
  end

  assign mem_ready  = ready_reg;
  assign wb_valid   = main_valid_reg;
  assign wb_regWe   = main_reg.reg_we & main_valid_reg;
  assign wb_regDest = main_reg.dest;
  assign wb_value   = main_reg.value;
  assign wb_hiloWe  = main_reg.hilo_we & main_valid_reg;
  assign wb_hi      = main_reg.hi;
  assign wb_lo      = main_reg.lo;

  // The skid entry is always younger than main, so it wins the bypass.
  always_comb begin
    if (skid_valid_reg) begin
      fwd_valid   = skid_reg.reg_we;
      fwd_regDest = skid_reg.dest;
      fwd_value   = skid_reg.value;
    end else begin
      fwd_valid   = main_valid_reg & main_reg.reg_we;
      fwd_regDest = main_reg.dest;
      fwd_value   = main_reg.value;
    end
  end

  assign count = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random traffic
// compared against a queue-based model of the two-entry buffer.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush, mem_valid, wb_ready;
  logic        mem_regWe, mem_hiloWe;
  logic [4:0]  mem_regDest;
  logic [31:0] mem_value, mem_hi, mem_lo;

  logic        mem_ready, wb_valid, wb_regWe, wb_hiloWe, fwd_valid;
  logic [4:0]  wb_regDest, fwd_regDest;
  logic [31:0] wb_value, wb_hi, wb_lo, fwd_value;
  logic [1:0]  count;

  logic        mem_ready_n, wb_valid_n, wb_regWe_n, wb_hiloWe_n, fwd_valid_n;
  logic [4:0]  wb_regDest_n, fwd_regDest_n;
  logic [31:0] wb_value_n, wb_hi_n, wb_lo_n, fwd_value_n;
  logic [1:0]  count_n;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_W(5), .HILO_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_regWe(mem_regWe), .mem_regDest(mem_regDest), .mem_value(mem_value),
    .mem_hiloWe(mem_hiloWe), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_regWe(wb_regWe), .wb_regDest(wb_regDest), .wb_value(wb_value),
    .wb_hiloWe(wb_hiloWe), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .fwd_valid(fwd_valid), .fwd_regDest(fwd_regDest), .fwd_value(fwd_value),
    .count(count)
  );

  mem_wb_stage #(.DATA_W(32), .REG_W(5), .HILO_EN(0)) dut_nohilo (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready_n),
    .mem_regWe(mem_regWe), .mem_regDest(mem_regDest), .mem_value(mem_value),
    .mem_hiloWe(mem_hiloWe), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid_n), .wb_ready(wb_ready),
    .wb_regWe(wb_regWe_n), .wb_regDest(wb_regDest_n), .wb_value(wb_value_n),
    .wb_hiloWe(wb_hiloWe_n), .wb_hi(wb_hi_n), .wb_lo(wb_lo_n),
    .fwd_valid(fwd_valid_n), .fwd_regDest(fwd_regDest_n), .fwd_value(fwd_value_n),
    .count(count_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] value;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    ent_t fw;
    logic fv;
    fw = (q.size() > 0) ? q[q.size()-1] : last;
    fv = (q.size() > 0) && fw.we;
    check_val("wb_valid",    64'(wb_valid),    64'(q.size() > 0));
    check_val("wb_regWe",    64'(wb_regWe),    64'((q.size() > 0) && last.we));
    check_val("wb_regDest",  64'(wb_regDest),  64'(last.dest));
    check_val("wb_value",    64'(wb_value),    64'(last.value));
    check_val("wb_hiloWe",   64'(wb_hiloWe),   64'((q.size() > 0) && last.hwe));
    check_val("wb_hi",       64'(wb_hi),       64'(last.hi));
    check_val("wb_lo",       64'(wb_lo),       64'(last.lo));
    check_val("mem_ready",   64'(mem_ready),   64'(q.size() < 2));
    check_val("count",       64'(count),       64'(q.size()));
    check_val("fwd_valid",   64'(fwd_valid),   64'(fv));
    check_val("fwd_regDest", 64'(fwd_regDest), 64'(fw.dest));
    check_val("fwd_value",   64'(fwd_value),   64'(fw.value));
    // Without the HI/LO channel the GPR path must behave identically.
    check_val("n_wb_valid",  64'(wb_valid_n),  64'(q.size() > 0));
    check_val("n_wb_value",  64'(wb_value_n),  64'(last.value));
    check_val("n_count",     64'(count_n),     64'(q.size()));
    check_val("n_wb_hiloWe", 64'(wb_hiloWe_n), 64'(0));
    check_val("n_wb_hi",     64'(wb_hi_n),     64'(0));
    check_val("n_wb_lo",     64'(wb_lo_n),     64'(0));
  endtask

  // Queue model: an entry is accepted whenever fewer than two are held,
  // the head leaves when WB is ready, and the bypass shows the newest one.
  task automatic model_edge();
    ent_t e;
    logic acc, drn;
    acc = mem_valid && (q.size() < 2);
    drn = (q.size() > 0) && wb_ready;
    if (rst) begin
      q.delete();
      last = '{default: '0};
    end else if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.we    = mem_regWe && (mem_regDest != 5'd0);
        e.dest  = mem_regDest;
        e.value = mem_value;
        e.hwe   = mem_hiloWe;
        e.hi    = mem_hi;
        e.lo    = mem_lo;
        q.push_back(e);
      end
    end
    if (q.size() > 0) last = q[0];
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic rdy,
                      input logic we, input logic [4:0] d, input logic [31:0] val,
                      input logic hwe, input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    check_all();
    rst = r; flush = f; mem_valid = v; wb_ready = rdy;
    mem_regWe = we; mem_regDest = d; mem_value = val;
    mem_hiloWe = hwe; mem_hi = h; mem_lo = l;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b0;
    mem_regWe = 1'b0; mem_regDest = '0; mem_value = '0;
    mem_hiloWe = 1'b0; mem_hi = '0; mem_lo = '0;
    last = '{default: '0};
    repeat (2) @(posedge clk);
    model_edge();

    // streaming
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h22, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h33, 1'b0, 32'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // backpressure then drain
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hA7, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'hB8, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'hC9, 1'b0, 32'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // register zero
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // flush with two buffered plus a same-cycle offer
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h1010, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h1111, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'h1212, 1'b0, 32'd0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // HI/LO
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 32'h5, 1'b1, 32'hAAAA_0000, 32'h0000_BBBB);
    idle(1'b1);
    idle(1'b1);

    // mid-operation reset with both entries held
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd13, 32'h1313, 1'b1, 32'h1, 32'h2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd14, 32'h1414, 1'b1, 32'h3, 32'h4);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd15, 32'h1515, 1'b1, 32'h5, 32'h6);
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), $urandom, $urandom);
    end
    @(negedge clk);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the result, HI and LO data.
REQ-002 SHALL have parameter REG_W, default 5, width of the register index.
REQ-003 SHALL have parameter HILO_EN, default 1; when 0, the HI/LO channel is disabled.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discards all buffered entries.
REQ-007 SHALL have port mem_valid  input  1  the MEM-side entry is valid.
REQ-008 SHALL have port mem_ready  output  1  the stage can accept an entry; registered.
REQ-009 SHALL have ports mem_regWe  input  1, mem_regDest  input  REG_W, mem_value  input  DATA_W: GPR write request.
REQ-010 SHALL have ports mem_hiloWe  input  1, mem_hi  input  DATA_W, mem_lo  input  DATA_W: HI/LO write request.
REQ-011 SHALL have port wb_valid  output  1  the WB-side entry is valid.
REQ-012 SHALL have port wb_ready  input  1  WB consumes the entry.
REQ-013 SHALL have outputs wb_regWe, wb_regDest, wb_value, wb_hiloWe, wb_hi, wb_lo, with the same widths as the mem_* ports.
REQ-014 SHALL have outputs fwd_valid  1, fwd_regDest  REG_W, fwd_value  DATA_W: bypass of the newest pending GPR write.
REQ-015 SHALL have output count  2  buffered entries, 0..2.

Function
REQ-016 SHALL hold two entries: main (drives wb_*) and skid.
REQ-017 SHALL treat accept = mem_valid & mem_ready and drain = wb_valid & wb_ready.
REQ-018 SHALL drive mem_ready = !skid_full, from a register.
REQ-019 SHALL, when empty and accept, load main next edge; latency 1 cycle.
REQ-020 SHALL, when main full with drain and accept, replace main with the input; skid stays empty.
REQ-021 SHALL, when main full with no drain and accept, load skid; mem_ready = 0 from next cycle.
REQ-022 SHALL, when skid full and drain, move skid into main and clear skid; mem_ready = 1 next cycle.
REQ-023 SHALL, when main full with drain and no accept (skid empty), clear main.
REQ-024 SHALL preserve order: entries leave in acceptance order, none lost or duplicated.
REQ-025 SHALL drive wb_valid = main valid.
REQ-026 SHALL gate wb_regWe and wb_hiloWe with wb_valid.
REQ-027 SHALL hold data outputs at their last value while invalid.
REQ-028 SHALL capture regWe as 0 when regDest == 0 (register zero is never written).
REQ-029 SHALL, when HILO_EN = 0, tie wb_hiloWe, wb_hi and wb_lo to 0 and ignore the mem_hilo* inputs.
REQ-030 SHALL take its forward source from skid if valid, else from main.
REQ-031 SHALL assert fwd_valid only when the forward source is valid and has regWe = 1; fwd_* are combinational from state.
REQ-032 SHALL, on flush, invalidate both entries at the next edge and drop any same-cycle accept.
REQ-033 SHALL, after flush, show mem_ready = 1 and count = 0.
REQ-034 SHALL give flush priority over accept and drain.
REQ-035 SHALL keep count equal to the number of valid entries at every cycle.

Reset
REQ-036 SHALL, with rst high at an edge, clear both entries whatever the state, with priority over flush.
REQ-037 SHALL, after reset, drive wb_valid = 0, wb_regWe = 0, wb_hiloWe = 0, wb_regDest = 0, wb_value = 0, wb_hi = 0, wb_lo = 0, mem_ready = 1, fwd_valid = 0, count = 0.
REQ-038 SHALL, after a mid-operation reset, discard all buffered entries; none reappears.

Verification
REQ-039 SHALL cover streaming: wb_ready = 1, accept dest 3/0x11, dest 4/0x22, dest 5/0x33 back-to-back -> wb_* show each in the next cycle, in order; count stays 1.
REQ-040 SHALL cover backpressure: wb_ready = 0, accept A (dest 7), then B (dest 8) -> count = 2, mem_ready = 0, fwd shows dest 8; wb_ready = 1 -> A, then B, then mem_ready = 1.
REQ-041 SHALL cover register zero: accept regWe = 1, regDest = 0, value 0xFFFFFFFF -> wb_valid = 1, wb_regWe = 0, fwd_valid = 0.
REQ-042 SHALL cover flush: two entries buffered plus mem_valid = 1 with flush = 1 -> next cycle count = 0, wb_valid = 0, mem_ready = 1; the dropped entry never appears.
REQ-043 SHALL cover HI/LO: HILO_EN = 1, accept hiloWe = 1, hi 0xAAAA0000, lo 0x0000BBBB -> wb_hi and wb_lo match; HILO_EN = 0 -> wb_hiloWe = 0, wb_hi = 0, wb_lo = 0.
REQ-044 SHALL cover mid-operation reset: rst = 1 while count = 2 -> all outputs at reset values next cycle.
